// File: rtl/snake_input_conditioner_if.sv
// rtl/snake_input_conditioner_if.sv - button inputs, direction queue and game-control outputs
interface snake_input_conditioner_if;
  logic       i_up;
  logic       i_down;
  logic       i_left;
  logic       i_right;
  logic       i_pause;
  logic       i_restart;
  logic       i_dir_pop;
  logic [1:0] o_dir;
  logic       o_dir_valid;
  logic       o_paused;
  logic       o_pause_tgl;
  logic       o_restart;

  modport master (
    output i_up, i_down, i_left, i_right, i_pause, i_restart, i_dir_pop,
    input  o_dir, o_dir_valid, o_paused, o_pause_tgl, o_restart
  );

  modport slave (
    input  i_up, i_down, i_left, i_right, i_pause, i_restart, i_dir_pop,
    output o_dir, o_dir_valid, o_paused, o_pause_tgl, o_restart
  );
endinterface

// File: rtl/snake_input_conditioner.sv
// rtl/snake_input_conditioner.sv - sync, debounce and direction queueing for the snake buttons
module snake_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 2
) (
  input logic                      clk,
  input logic                      rst,
  snake_input_conditioner_if.slave bus
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [DBW-1:0] DB_LIMIT = DBW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 pause, 5 restart
  logic [5:0]     raw;
  logic [5:0]     sync_r [SYNC_STAGES];
  logic [5:0]     synced;
  logic [DBW-1:0] db_cnt [6];
  logic [5:0]     stable;
  logic [5:0]     stable_q;
  logic [5:0]     press;

  logic [1:0]     q [FIFO_DEPTH];
  logic [1:0]     q_next [FIFO_DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [CW-1:0]  wr_cnt;
  logic [1:0]     heading;
  logic           paused;
  logic           pause_tgl;
  logic           restart;

  logic           pop;
  logic           full;
  logic           cand_valid;
  logic [1:0]     cand;
  logic [1:0]     ref_dir;
  logic           accept;

  assign raw    = {bus.i_restart, bus.i_pause, bus.i_right, bus.i_left, bus.i_down, bus.i_up};
  assign synced = sync_r[SYNC_STAGES-1];
  assign press  = stable & ~stable_q;

  assign bus.o_dir       = q[0];
  assign bus.o_dir_valid = (count != '0);
  assign bus.o_paused    = paused;
  assign bus.o_pause_tgl = pause_tgl;
  assign bus.o_restart   = restart;

  // Synchronise every button, then accept a new level only after it has persisted
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      for (int k = 0; k < 6; k++) db_cnt[k] <= '0;
      stable   <= '0;
      stable_q <= '0;
    end else begin
      sync_r[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      stable_q <= stable;
      for (int k = 0; k < 6; k++) begin
        if (synced[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LIMIT) begin
          stable[k] <= synced[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Pick one direction candidate, check it against the newest queued heading, build next queue
  always_comb begin
    pop        = bus.i_dir_pop & (count != '0);
    full       = (count == FULL_CNT);
    cand_valid = |press[3:0];
    if (press[0])      cand = 2'b00;
    else if (press[1]) cand = 2'b01;
    else if (press[2]) cand = 2'b10;
    else               cand = 2'b11;

    // Compare against the last queued entry so chained turns are judged in order
    ref_dir = heading;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i + 1) == count) ref_dir = q[i];
    end

    accept = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01)) && (!full || pop);

    for (int i = 0; i < FIFO_DEPTH; i++) q_next[i] = q[i];
    count_next = count;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) q_next[i] = q[i+1];
      q_next[FIFO_DEPTH-1] = 2'b00;
      count_next = count - 1'b1;
    end
    wr_cnt = pop ? count - 1'b1 : count;
    if (accept) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == wr_cnt) q_next[i] = cand;
      end
      count_next = count_next + 1'b1;
    end
  end

  // Game-facing state: restart wins over every other same-cycle event
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= 2'b00;
      count     <= '0;
      heading   <= 2'b11;
      paused    <= 1'b0;
      pause_tgl <= 1'b0;
      restart   <= 1'b0;
    end else begin
      pause_tgl <= 1'b0;
      restart   <= 1'b0;
      if (press[5]) begin
        restart <= 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= 2'b00;
        count   <= '0;
        heading <= 2'b11;
        paused  <= 1'b0;
      end else begin
        if (press[4]) begin
          paused    <= ~paused;
          pause_tgl <= 1'b1;
        end
        if (pop) heading <= q[0];
        for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= q_next[i];
        count <= count_next;
      end
    end
  end
endmodule

// File: tb/tb_snake_input_conditioner.sv
// tb/tb_snake_input_conditioner.sv - directed scoreboard bench for snake_input_conditioner
module tb_snake_input_conditioner;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [1:0] exp_q [$];
  logic [1:0] m_heading;
  logic       m_paused;

  snake_input_conditioner_if bus ();

  snake_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] b);
    bus.i_up      = b[0];
    bus.i_down    = b[1];
    bus.i_left    = b[2];
    bus.i_right   = b[3];
    bus.i_pause   = b[4];
    bus.i_restart = b[5];
  endtask

  task automatic do_reset();
    drive(6'b0);
    bus.i_dir_pop = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_heading = 2'b11;
    m_paused  = 1'b0;
    chk("rst_valid",   bus.o_dir_valid, 8'd0);
    chk("rst_dir",     bus.o_dir,       8'd0);
    chk("rst_paused",  bus.o_paused,    8'd0);
    chk("rst_tgl",     bus.o_pause_tgl, 8'd0);
    chk("rst_restart", bus.o_restart,   8'd0);
  endtask

  task automatic pop_dir();
    if (exp_q.size() > 0) chk("pop_head", bus.o_dir, exp_q[0]);
    bus.i_dir_pop = 1'b1;
    @(negedge clk);
    bus.i_dir_pop = 1'b0;
    if (exp_q.size() > 0) m_heading = exp_q.pop_front();
    chk("pop_valid", bus.o_dir_valid, (exp_q.size() != 0));
    if (exp_q.size() > 0) chk("pop_next_head", bus.o_dir, exp_q[0]);
  endtask

  // Hold buttons from the next edge (edge 0); the event must land at edge 7 exactly
  task automatic press(input logic [5:0] btn, input bit with_pop, input int hold);
    logic [1:0] rd;
    logic [1:0] cd;
    bit cv;
    bit popping;
    bit acc;
    bit full;
    drive(btn);
    repeat (7) @(negedge clk);
    chk("pre_valid", bus.o_dir_valid, (exp_q.size() != 0));
    chk("pre_tgl", bus.o_pause_tgl, 8'd0);
    chk("pre_restart", bus.o_restart, 8'd0);
    popping = with_pop && (exp_q.size() > 0);
    if (popping) chk("press_pop_dir", bus.o_dir, exp_q[0]);
    bus.i_dir_pop = with_pop;
    @(negedge clk);
    bus.i_dir_pop = 1'b0;
    if (btn[5]) begin
      exp_q.delete();
      m_heading = 2'b11;
      m_paused  = 1'b0;
    end else begin
      if (btn[4]) m_paused = !m_paused;
      cv = |btn[3:0];
      cd = btn[0] ? 2'b00 : btn[1] ? 2'b01 : btn[2] ? 2'b10 : 2'b11;
      rd = (exp_q.size() > 0) ? exp_q[$] : m_heading;
      full = (exp_q.size() >= 2);
      acc = cv && (cd != rd) && (cd != (rd ^ 2'b01)) && (!full || popping);
      if (popping) m_heading = exp_q.pop_front();
      if (acc) exp_q.push_back(cd);
    end
    chk("ev_restart", bus.o_restart, btn[5]);
    chk("ev_tgl", bus.o_pause_tgl, btn[4] & ~btn[5]);
    chk("ev_paused", bus.o_paused, m_paused);
    chk("ev_valid", bus.o_dir_valid, (exp_q.size() != 0));
    if (exp_q.size() > 0) chk("ev_head", bus.o_dir, exp_q[0]);
    @(negedge clk);
    chk("post_restart", bus.o_restart, 8'd0);
    chk("post_tgl", bus.o_pause_tgl, 8'd0);
    repeat (hold) @(negedge clk);
    drive(6'b0);
    repeat (10) @(negedge clk);
    chk("rel_valid", bus.o_dir_valid, (exp_q.size() != 0));
    chk("rel_paused", bus.o_paused, m_paused);
    chk("rel_tgl", bus.o_pause_tgl, 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(6'b0);
    bus.i_dir_pop = 1'b0;
    @(negedge clk);
    do_reset();

    // Held up: one entry at edge 7, none more while held
    press(6'b000001, 1'b0, 20);
    pop_dir();
    pop_dir();

    // Reversal and duplicate against the reset heading, then heading follows a pop
    do_reset();
    press(6'b000100, 1'b0, 0);
    press(6'b001000, 1'b0, 0);
    press(6'b000001, 1'b0, 0);
    pop_dir();
    press(6'b000010, 1'b0, 0);

    // Bounce shorter than the debounce window is ignored
    for (int c = 0; c < 5; c++) begin
      bus.i_right = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_right = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("bounce_valid", bus.o_dir_valid, (exp_q.size() != 0));
    press(6'b001000, 1'b0, 2);
    pop_dir();

    // Fill the queue, drop on full, then push while popping
    press(6'b000001, 1'b0, 0);
    press(6'b000100, 1'b0, 0);
    press(6'b000010, 1'b0, 0);
    press(6'b000010, 1'b1, 0);
    pop_dir();
    pop_dir();

    // Pause toggles, then restart clears pause, queue and heading
    press(6'b010000, 1'b0, 0);
    press(6'b010000, 1'b0, 0);
    press(6'b001000, 1'b0, 0);
    pop_dir();
    press(6'b000001, 1'b0, 0);
    press(6'b010000, 1'b0, 0);
    press(6'b100000, 1'b0, 0);
    press(6'b000100, 1'b0, 0);
    press(6'b000001, 1'b0, 0);
    pop_dir();

    // Restart swallows same-cycle direction and pause presses
    press(6'b010000, 1'b0, 0);
    press(6'b110001, 1'b0, 0);

    // Reset in the middle of a debounce leaves nothing behind
    bus.i_up = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.i_up = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_valid", bus.o_dir_valid, 8'd0);
    chk("midrst_restart", bus.o_restart, 8'd0);
    chk("midrst_paused", bus.o_paused, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
